// File: rtl/mc_control.sv
// Multi-cycle MIPS main control: sequences fetch through write-back and counts retired instructions.
// Define MC_BNE_EN to accept bne (000101) as a branch on !zero; otherwise it decodes as illegal.
module mc_control (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_branch,
   output logic [1:0]  pc_source,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        ext_zero,
   output logic [2:0]  ula_operation,
   output logic        illegal,
   output logic        retired,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
      R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB
   } state_t;

   state_t      state, next;
   logic [31:0] count;

   logic is_lw, is_sw, is_r, is_beq, is_bne, is_j, is_imm;

   assign is_lw  = (opcode == 6'b100011);
   assign is_sw  = (opcode == 6'b101011);
   assign is_r   = (opcode == 6'b000000);
   assign is_beq = (opcode == 6'b000100);
   assign is_bne = (opcode == 6'b000101);
   assign is_j   = (opcode == 6'b000010);
   assign is_imm = (opcode == 6'b001000) || (opcode == 6'b001010) ||
                   (opcode == 6'b001100) || (opcode == 6'b001101) ||
                   (opcode == 6'b001110) || (opcode == 6'b001111);

   assign instr_count = count;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= FETCH;
         count <= '0;
      end else begin
         state <= next;
         if (retired)
            count <= count + 32'd1;
      end
   end

   always_comb begin
      next          = state;
      pc_write      = 1'b0;
      pc_branch     = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      ext_zero      = 1'b0;
      ula_operation = 3'b000;
      illegal       = 1'b0;
      retired       = 1'b0;
      // Everything stays quiet while reset is asserted.
      if (reset_n) begin
         unique case (state)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               if (mem_ready)
                  next = DECODE;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               unique case (1'b1)
                  is_lw, is_sw: next = MEM_ADDR;
                  is_r:         next = R_EXEC;
                  is_beq:       next = BRANCH;
`ifdef MC_BNE_EN
                  is_bne:       next = BRANCH;
`endif
                  is_j:         next = JUMP;
                  is_imm:       next = I_EXEC;
                  default: begin
                     illegal = 1'b1;
                     next    = FETCH;
                  end
               endcase
            end
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               next      = is_sw ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
               if (mem_ready)
                  next = MEM_WB;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               retired    = 1'b1;
               next       = FETCH;
            end
            MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
               retired   = mem_ready;
               if (mem_ready)
                  next = FETCH;
            end
            R_EXEC: begin
               alu_src_a     = 1'b1;
               ula_operation = 3'b010;
               next          = R_WB;
            end
            R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               retired   = 1'b1;
               next      = FETCH;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               ula_operation = 3'b001;
               pc_source     = 2'b01;
               pc_branch     = is_bne ? !zero : zero;
               retired       = 1'b1;
               next          = FETCH;
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
               retired   = 1'b1;
               next      = FETCH;
            end
            I_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               unique case (opcode)
                  6'b001010: ula_operation = 3'b011;
                  6'b001100: begin ula_operation = 3'b100; ext_zero = 1'b1; end
                  6'b001101: begin ula_operation = 3'b101; ext_zero = 1'b1; end
                  6'b001110: begin ula_operation = 3'b110; ext_zero = 1'b1; end
                  6'b001111: ula_operation = 3'b111;
                  default:   ula_operation = 3'b000;
               endcase
               next = I_WB;
            end
            I_WB: begin
               reg_write = 1'b1;
               retired   = 1'b1;
               next      = FETCH;
            end
            default: next = FETCH;
         endcase
      end
   end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle main control unit for the MIPS datapath. Sequences one instruction at a time through fetch, decode, execute, memory and write-back states. Drives the datapath mux selects and write strobes, and feeds the 3-bit ALU-operation code consumed by the existing ALU-control decoder. Stretches memory states on a ready handshake and counts retired instructions.

## Interface
- No parameters.
- `clock` in 1: single clock, all state on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `opcode` in 6: instruction[31:26] from the instruction register; stable from DECODE until the next FETCH.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_branch` out 1: conditional PC load (branch taken).
- `pc_source` out 2: 00 = ALU result, 01 = ALU-out register, 10 = jump target.
- `i_or_d` out 1: memory address select, 0 = PC, 1 = ALU-out.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: instruction-register load.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `mem_to_reg` out 1: 1 = MDR, 0 = ALU-out.
- `reg_write` out 1: register-file write.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = extended immediate, 11 = immediate<<2.
- `ext_zero` out 1: 1 = zero-extend immediate.
- `ula_operation` out 3: code for the ALU-control decoder.
- `illegal` out 1: one-cycle pulse on an unknown opcode.
- `retired` out 1: one-cycle pulse when an instruction completes.
- `instr_count` out 32: retired-instruction counter.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB.
- Outputs are decoded from the state (Moore), except strobes gated by `mem_ready` or `zero`.
- Any output not listed for a state is 0.
- **FETCH**
  - Outputs: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `ula_operation`=000.
  - `ir_write` and `pc_write` follow `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- **DECODE**
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `ula_operation`=000.
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) → MEM_ADDR.
    - 000000 → R_EXEC.
    - 000100 (beq) → BRANCH.
    - 000010 (j) → JUMP.
    - 001000, 001010, 001100, 001101, 001110, 001111 → I_EXEC.
    - Any other opcode → FETCH with `illegal`=1 for that cycle; no retire.
- **MEM_ADDR**
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `ula_operation`=000.
  - Next: lw → MEM_READ, sw → MEM_WRITE.
- **MEM_READ**
  - Outputs: `mem_read`=1, `i_or_d`=1.
  - Waits for `mem_ready`, then → MEM_WB.
- **MEM_WB**
  - Outputs: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - Retires; → FETCH.
- **MEM_WRITE**
  - Outputs: `mem_write`=1, `i_or_d`=1.
  - Waits for `mem_ready`; retires on `mem_ready`=1 and → FETCH.
- **R_EXEC**
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `ula_operation`=010.
  - Next: R_WB.
- **R_WB**
  - Outputs: `reg_write`=1, `reg_dst`=1.
  - Retires; → FETCH.
- **BRANCH**
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `ula_operation`=001, `pc_source`=01.
  - `pc_branch`=`zero` for beq.
  - Retires; → FETCH.
- **JUMP**
  - Outputs: `pc_write`=1, `pc_source`=10.
  - Retires; → FETCH.
- **I_EXEC**
  - Outputs: `alu_src_a`=1, `alu_src_b`=10.
  - `ula_operation` by opcode: addi 000, slti 011, andi 100, ori 101, xori 110, lui 111.
  - `ext_zero`=1 for andi, ori, xori.
  - Next: I_WB.
- **I_WB**
  - Outputs: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - Retires; → FETCH.
- **Retire**
  - `retired`=1 for the completing cycle.
  - `instr_count` increments on the next edge and wraps 0xFFFFFFFF → 0.

## Timing
- **Reset.** While `reset_n`=0 at an edge, the next state is FETCH and `instr_count` becomes 0. During any cycle with `reset_n`=0, all strobes (`pc_write`, `pc_branch`, `ir_write`, `mem_read`, `mem_write`, `reg_write`, `illegal`, `retired`) and all selects are forced to 0. Reset mid-instruction abandons the instruction without retiring it.
- **Cycles with zero wait states:** R-type 4, lw 5, sw 4, beq/bne 3, j 3, I-type 4, illegal 2.
- **Wait states.** Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Strobes gated by `mem_ready` (`ir_write`, `pc_write` in FETCH; the retire in MEM_WRITE) fire only on the ready cycle. `mem_read`/`mem_write` stay high throughout the wait.
- `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.

## Configuration
- `MC_BNE_EN` defined:
  - Opcode 000101 (bne) → BRANCH, with `pc_branch`=!`zero`.
- `MC_BNE_EN` undefined:
  - 000101 is illegal: DECODE → FETCH with an `illegal` pulse.

## Test plan
- Reset held 3 cycles, then an R-type (opcode 000000) with `mem_ready`=1 → state sequence FETCH, DECODE, R_EXEC, R_WB; `ula_operation`=010 in R_EXEC; `reg_write`=`reg_dst`=1 in R_WB; `instr_count`=1.
- lw (100011) with `mem_ready` low for 2 cycles in MEM_READ → 7 cycles total; `mem_read`=`i_or_d`=1 throughout MEM_READ; `mem_to_reg`=1 in MEM_WB.
- beq (000100) with `zero`=1, then again with `zero`=0 → `pc_branch`=1 and 0 respectively in BRANCH; `ula_operation`=001; both retire.
- ori (001101) → `ula_operation`=101 and `ext_zero`=1 in I_EXEC; lui (001111) → `ula_operation`=111 and `ext_zero`=0.
- Opcode 111111, and 000101 without `MC_BNE_EN` → `illegal` pulse in DECODE, back to FETCH, `instr_count` unchanged.
- `reset_n` low during a MEM_WRITE wait, plus `instr_count` preloaded via 2^32−1 retires (or forced) → reset gives FETCH with all strobes 0 and count 0; the wrap case gives 0xFFFFFFFF → 0.
